// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stage-register enables/flushes and execute-stage forwarding selects.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush/load-use event counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned FLUSH_EXTRA    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      regWriteE_i,
    input  logic                      resultSrcE_i,
    input  logic [REG_ADDR_WIDTH-1:0] AD3E_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1E_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2E_i,
    input  logic                      regWriteM_i,
    input  logic [REG_ADDR_WIDTH-1:0] AD3M_i,
    input  logic                      regWriteW_i,
    input  logic [REG_ADDR_WIDTH-1:0] AD3W_i,
    input  logic                      branchTakenE_i,
    input  logic                      JALE_i,
    input  logic                      JALRE_i,
    input  logic                      memBusy_i,
    output logic                      enF_o,
    output logic                      enD_o,
    output logic                      enE_o,
    output logic                      flushD_o,
    output logic                      flushE_o,
    output logic [1:0]                fwdAE_o,
    output logic [1:0]                fwdBE_o
`ifdef HAZARD_PERF_EN
    ,
    output logic [15:0]               stallCnt_o,
    output logic [15:0]               flushCnt_o,
    output logic [15:0]               loadUseCnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_LOAD_STALL = 2'd2,
        ST_FLUSH      = 2'd3
    } state_t;

    localparam logic [REG_ADDR_WIDTH-1:0] REG_X0     = {REG_ADDR_WIDTH{1'b0}};
    localparam logic [1:0]                FLUSH_LOAD = 2'(FLUSH_EXTRA);
    localparam logic                      HAS_EXTRA  = (FLUSH_EXTRA != 32'd0);

    state_t     state_r;
    state_t     state_nxt_s;
    logic [1:0] flush_cnt_r;
    logic [1:0] flush_cnt_nxt_s;
    logic       load_use_s;
    logic       redirect_s;
    logic       en_f_s;
    logic       en_d_s;
    logic       en_e_s;
    logic       flush_d_s;
    logic       flush_e_s;
    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;

    // M-stage result wins over W-stage; x0 is never a forwarding source.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_WIDTH-1:0] rs,
        input logic                      wr_m,
        input logic [REG_ADDR_WIDTH-1:0] dst_m,
        input logic                      wr_w,
        input logic [REG_ADDR_WIDTH-1:0] dst_w
    );
        logic [1:0] sel;
        if (wr_m && (dst_m != REG_X0) && (dst_m == rs)) begin
            sel = 2'b10;
        end else if (wr_w && (dst_w != REG_X0) && (dst_w == rs)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Hazard detection terms and forwarding selects.
    always_comb begin
        load_use_s = resultSrcE_i && regWriteE_i && (AD3E_i != REG_X0) &&
                     ((AD3E_i == rs1D_i) || (AD3E_i == rs2D_i));
        redirect_s = branchTakenE_i | JALE_i | JALRE_i;
        fwd_a_s    = fwd_sel(rs1E_i, regWriteM_i, AD3M_i, regWriteW_i, AD3W_i);
        fwd_b_s    = fwd_sel(rs2E_i, regWriteM_i, AD3M_i, regWriteW_i, AD3W_i);
    end

    // Next-state and stage control; MEM_WAIT and LOAD_STALL share the RUN priority chain.
    always_comb begin
        state_nxt_s     = state_r;
        flush_cnt_nxt_s = flush_cnt_r;
        en_f_s          = 1'b1;
        en_d_s          = 1'b1;
        en_e_s          = 1'b1;
        flush_d_s       = 1'b0;
        flush_e_s       = 1'b0;
        case (state_r)
            ST_RUN, ST_MEM_WAIT, ST_LOAD_STALL: begin
                if (memBusy_i) begin
                    en_f_s      = 1'b0;
                    en_d_s      = 1'b0;
                    en_e_s      = 1'b0;
                    state_nxt_s = ST_MEM_WAIT;
                end else if (redirect_s) begin
                    flush_d_s = 1'b1;
                    flush_e_s = 1'b1;
                    if (HAS_EXTRA) begin
                        state_nxt_s     = ST_FLUSH;
                        flush_cnt_nxt_s = FLUSH_LOAD;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else if (load_use_s && (state_r != ST_LOAD_STALL)) begin
                    en_f_s      = 1'b0;
                    en_d_s      = 1'b0;
                    flush_e_s   = 1'b1;
                    state_nxt_s = ST_LOAD_STALL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (memBusy_i) begin
                    en_f_s = 1'b0;
                    en_d_s = 1'b0;
                    en_e_s = 1'b0;
                end else if (redirect_s) begin
                    flush_d_s       = 1'b1;
                    flush_e_s       = 1'b1;
                    flush_cnt_nxt_s = FLUSH_LOAD;
                end else begin
                    flush_d_s = 1'b1;
                    if (flush_cnt_r <= 2'd1) begin
                        state_nxt_s     = ST_RUN;
                        flush_cnt_nxt_s = 2'd0;
                    end else begin
                        flush_cnt_nxt_s = flush_cnt_r - 2'd1;
                    end
                end
            end
            default: begin
                en_f_s          = 1'b0;
                en_d_s          = 1'b0;
                en_e_s          = 1'b0;
                flush_d_s       = 1'b1;
                flush_e_s       = 1'b1;
                state_nxt_s     = ST_RUN;
                flush_cnt_nxt_s = 2'd0;
            end
        endcase
    end

    // Reset forces bubbles and freezes every stage immediately, not just at the next edge.
    always_comb begin
        if (rst) begin
            enF_o    = 1'b0;
            enD_o    = 1'b0;
            enE_o    = 1'b0;
            flushD_o = 1'b1;
            flushE_o = 1'b1;
            fwdAE_o  = 2'b00;
            fwdBE_o  = 2'b00;
        end else begin
            enF_o    = en_f_s;
            enD_o    = en_d_s;
            enE_o    = en_e_s;
            flushD_o = flush_d_s;
            flushE_o = flush_e_s;
            fwdAE_o  = fwd_a_s;
            fwdBE_o  = fwd_b_s;
        end
    end

    // FSM state and flush counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_RUN;
            flush_cnt_r <= 2'd0;
        end else begin
            state_r     <= state_nxt_s;
            flush_cnt_r <= flush_cnt_nxt_s;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [15:0] stall_cnt_r;
    logic [15:0] flush_cnt_perf_r;
    logic [15:0] load_use_cnt_r;
    logic        load_use_evt_s;

    // Only the load-use bubble freezes F/D while E still advances.
    always_comb begin
        load_use_evt_s = en_e_s & ~en_d_s;
    end

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r      <= 16'd0;
            flush_cnt_perf_r <= 16'd0;
            load_use_cnt_r   <= 16'd0;
        end else begin
            if (!en_f_s && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end
            if (flush_d_s && (flush_cnt_perf_r != 16'hFFFF)) begin
                flush_cnt_perf_r <= flush_cnt_perf_r + 16'd1;
            end
            if (load_use_evt_s && (load_use_cnt_r != 16'hFFFF)) begin
                load_use_cnt_r <= load_use_cnt_r + 16'd1;
            end
        end
    end

    assign stallCnt_o   = stall_cnt_r;
    assign flushCnt_o   = flush_cnt_perf_r;
    assign loadUseCnt_o = load_use_cnt_r;
`else
    // Core-only build: no event counters.
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed test-plan sequences plus random traffic
// checked against a cycle-level behavioural model of the stall/flush rules.
module tb_pipeline_hazard_ctrl;
    localparam int W  = 5;
    localparam int FX = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         regWriteE = 1'b0, resultSrcE = 1'b0, regWriteM = 1'b0, regWriteW = 1'b0;
    logic [W-1:0] AD3E = '0, rs1D = '0, rs2D = '0, rs1E = '0, rs2E = '0, AD3M = '0, AD3W = '0;
    logic         branchTakenE = 1'b0, JALE = 1'b0, JALRE = 1'b0, memBusy = 1'b0;
    logic         enF, enD, enE, flushD, flushE;
    logic [1:0]   fwdAE, fwdBE;
`ifdef HAZARD_PERF_EN
    logic [15:0]  stallCnt, flushCnt, loadUseCnt;
`endif

    pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(W), .FLUSH_EXTRA(FX)) dut (
        .clk(clk), .rst(rst),
        .regWriteE_i(regWriteE), .resultSrcE_i(resultSrcE), .AD3E_i(AD3E),
        .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E),
        .regWriteM_i(regWriteM), .AD3M_i(AD3M), .regWriteW_i(regWriteW), .AD3W_i(AD3W),
        .branchTakenE_i(branchTakenE), .JALE_i(JALE), .JALRE_i(JALRE), .memBusy_i(memBusy),
        .enF_o(enF), .enD_o(enD), .enE_o(enE), .flushD_o(flushD), .flushE_o(flushE),
        .fwdAE_o(fwdAE), .fwdBE_o(fwdBE)
`ifdef HAZARD_PERF_EN
        , .stallCnt_o(stallCnt), .flushCnt_o(flushCnt), .loadUseCnt_o(loadUseCnt)
`endif
    );

    typedef struct packed {
        logic         rst, rwE, ldE;
        logic [W-1:0] ad3E, rs1D, rs2D, rs1E, rs2E;
        logic         rwM;
        logic [W-1:0] ad3M;
        logic         rwW;
        logic [W-1:0] ad3W;
        logic         br, jal, jalr, busy;
    } stim_t;

    typedef struct packed {
        logic [2:0]  en;   // {F,D,E}
        logic [1:0]  fl;   // {D,E}
        logic [1:0]  fa, fb;
        logic [15:0] sc, fc, lc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model state: extra decode-flush cycles still owed, and whether the previous cycle was the load bubble.
    int   flush_left = 0;
    bit   bubble_prev = 1'b0;
    int   m_stall = 0, m_flush = 0, m_lu = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [1:0] model_fwd(input stim_t s, input logic [W-1:0] rs);
        if (rs == 0) return 2'b00;
        if (s.rwM && s.ad3M == rs) return 2'b10;
        if (s.rwW && s.ad3W == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   lu, rd, lu_taken;
        @(posedge clk);
        #1;
        rst = s.rst; regWriteE = s.rwE; resultSrcE = s.ldE; AD3E = s.ad3E;
        rs1D = s.rs1D; rs2D = s.rs2D; rs1E = s.rs1E; rs2E = s.rs2E;
        regWriteM = s.rwM; AD3M = s.ad3M; regWriteW = s.rwW; AD3W = s.ad3W;
        branchTakenE = s.br; JALE = s.jal; JALRE = s.jalr; memBusy = s.busy;

        lu = s.ldE && s.rwE && (s.ad3E != 0) && (s.ad3E == s.rs1D || s.ad3E == s.rs2D);
        rd = s.br || s.jal || s.jalr;
        lu_taken = 1'b0;
        if (s.rst) begin
            m_stall = 0; m_flush = 0; m_lu = 0;
        end
        e = '0;
        e.sc = 16'(m_stall); e.fc = 16'(m_flush); e.lc = 16'(m_lu);
        if (s.rst) begin
            e.en = 3'b000; e.fl = 2'b11;
            flush_left = 0; bubble_prev = 1'b0;
        end else begin
            e.fa = model_fwd(s, s.rs1E);
            e.fb = model_fwd(s, s.rs2E);
            if (s.busy) begin
                e.en = 3'b000; e.fl = 2'b00; bubble_prev = 1'b0;
            end else if (rd) begin
                e.en = 3'b111; e.fl = 2'b11; flush_left = FX; bubble_prev = 1'b0;
            end else if (flush_left > 0) begin
                e.en = 3'b111; e.fl = 2'b10; flush_left--;
            end else if (lu && !bubble_prev) begin
                e.en = 3'b001; e.fl = 2'b01; bubble_prev = 1'b1; lu_taken = 1'b1;
            end else begin
                e.en = 3'b111; e.fl = 2'b00; bubble_prev = 1'b0;
            end
            if (!e.en[2] && m_stall < 65535) m_stall++;
            if (e.fl[1] && m_flush < 65535) m_flush++;
            if (lu_taken && m_lu < 65535) m_lu++;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: every negedge the DUT presents a full output set for the cycle just driven.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("enables", 16'({enF, enD, enE}), 16'(e.en));
                chk("flushes", 16'({flushD, flushE}), 16'(e.fl));
                chk("fwdAE", 16'(fwdAE), 16'(e.fa));
                chk("fwdBE", 16'(fwdBE), 16'(e.fb));
`ifdef HAZARD_PERF_EN
                chk("stallCnt", stallCnt, e.sc);
                chk("flushCnt", flushCnt, e.fc);
                chk("loadUseCnt", loadUseCnt, e.lc);
`endif
            end
        end
    end

    initial begin
        stim_t s;
        stim_t idle;
        idle = '0;

        s = idle; s.rst = 1'b1; step(s); step(s);
        step(idle);
        // load-use on rs1, then bubble cycle
        s = idle; s.rwE = 1'b1; s.ldE = 1'b1; s.ad3E = 5'd5; s.rs1D = 5'd5; step(s);
        step(idle);
        // x0 destination never stalls
        s.ad3E = 5'd0; s.rs1D = 5'd0; step(s);
        step(idle);
        // forwarding priority M over W, then W alone
        s = idle; s.rwM = 1'b1; s.ad3M = 5'd3; s.rwW = 1'b1; s.ad3W = 5'd3;
        s.rs1E = 5'd3; s.rs2E = 5'd3; step(s);
        s.rwM = 1'b0; step(s);
        // JALR redirect with extra flush cycles
        s = idle; s.jalr = 1'b1; step(s);
        repeat (4) step(idle);
        // memBusy held with a taken branch
        s = idle; s.busy = 1'b1; s.br = 1'b1;
        repeat (4) step(s);
        s.busy = 1'b0; step(s);
        repeat (4) step(idle);
        // reset asserted mid-flush
        s = idle; s.jal = 1'b1; step(s);
        step(idle);
        s = idle; s.rst = 1'b1; step(s); step(s);
        step(idle); step(idle);
        // two load-use events and a three-cycle memory wait
        s = idle; s.rst = 1'b1; step(s);
        s = idle; s.rwE = 1'b1; s.ldE = 1'b1; s.ad3E = 5'd7; s.rs2D = 5'd7; step(s);
        step(idle);
        step(s);
        step(idle);
        s = idle; s.busy = 1'b1;
        repeat (3) step(s);
        repeat (2) step(idle);

        for (int i = 0; i < 3000; i++) begin
            s.rst  = ($urandom_range(0, 199) == 0);
            s.rwE  = 1'($urandom_range(0, 1));
            s.ldE  = 1'($urandom_range(0, 1));
            s.ad3E = 5'($urandom_range(0, 3));
            s.rs1D = 5'($urandom_range(0, 3));
            s.rs2D = 5'($urandom_range(0, 3));
            s.rs1E = 5'($urandom_range(0, 3));
            s.rs2E = 5'($urandom_range(0, 3));
            s.rwM  = 1'($urandom_range(0, 1));
            s.ad3M = 5'($urandom_range(0, 3));
            s.rwW  = 1'($urandom_range(0, 1));
            s.ad3W = 5'($urandom_range(0, 3));
            s.br   = ($urandom_range(0, 9) == 0);
            s.jal  = ($urandom_range(0, 19) == 0);
            s.jalr = ($urandom_range(0, 19) == 0);
            s.busy = ($urandom_range(0, 4) == 0);
            step(s);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
